// File: rtl/ws2812_write_arbiter.sv
// Round-robin arbiter in front of the WS2812 driver write port; expands fill commands into NUM_LEDS writes.
// Optional brightness shift on the outgoing colour when WS2812_DIM_EN is defined (adds the dim port).
module ws2812_write_arbiter #(
  parameter int NUM_LEDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_fill,
  input  logic [7:0]  a_led,
  input  logic [23:0] a_rgb,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_fill,
  input  logic [7:0]  b_led,
  input  logic [23:0] b_rgb,
  output logic        wr_en,
  output logic [7:0]  wr_led,
  output logic [23:0] wr_rgb,
  output logic        busy,
  output logic        err_range
`ifdef WS2812_DIM_EN
  ,
  input  logic [2:0]  dim
`endif
);

  localparam int IW = $clog2(NUM_LEDS) + 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [23:0]   fill_rgb, fill_rgb_nxt;
  logic          prio_b, prio_b_nxt;
  logic          err_nxt;
  logic          wr_en_nxt;
  logic [7:0]    wr_led_nxt;
  logic [23:0]   wr_rgb_nxt;
  logic          grant_a, grant_b;
  logic          take_fill;
  logic [7:0]    take_led;
  logic [23:0]   take_rgb;
  logic [2:0]    dim_s;

`ifdef WS2812_DIM_EN
  assign dim_s = dim;
`else
  assign dim_s = 3'd0;
`endif

  // Per-byte logical right shift; a zero shift folds away entirely.
  function automatic logic [23:0] shade(input logic [23:0] c, input logic [2:0] s);
    return {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
  endfunction

  assign busy = (state == FILL);

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    fill_rgb_nxt = fill_rgb;
    prio_b_nxt   = prio_b;
    err_nxt      = err_range;
    wr_en_nxt    = 1'b0;
    wr_led_nxt   = wr_led;
    wr_rgb_nxt   = wr_rgb;

    grant_a   = (state == IDLE) && !reset && a_valid && (!b_valid || !prio_b);
    grant_b   = (state == IDLE) && !reset && b_valid && (!a_valid || prio_b);
    a_ready   = grant_a;
    b_ready   = grant_b;
    take_fill = grant_b ? b_fill : a_fill;
    take_led  = grant_b ? b_led  : a_led;
    take_rgb  = grant_b ? b_rgb  : a_rgb;

    case (state)
      IDLE: begin
        if (grant_a || grant_b) begin
          prio_b_nxt = grant_a;
          if (take_fill) begin
            // The first fill write is issued on the accept edge itself.
            state_nxt    = FILL;
            idx_nxt      = '0;
            fill_rgb_nxt = take_rgb;
            wr_en_nxt    = 1'b1;
            wr_led_nxt   = 8'd0;
            wr_rgb_nxt   = shade(take_rgb, dim_s);
          end else if (take_led < 8'(NUM_LEDS)) begin
            wr_en_nxt  = 1'b1;
            wr_led_nxt = take_led;
            wr_rgb_nxt = shade(take_rgb, dim_s);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      FILL: begin
        // idx is the LED currently on the outputs.
        if (idx == IW'(NUM_LEDS - 1)) begin
          state_nxt = IDLE;
        end else begin
          idx_nxt    = idx + IW'(1);
          wr_en_nxt  = 1'b1;
          wr_led_nxt = 8'(idx_nxt);
          wr_rgb_nxt = shade(fill_rgb, dim_s);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      prio_b    <= 1'b0;
      err_range <= 1'b0;
      wr_en     <= 1'b0;
      wr_led    <= 8'd0;
      wr_rgb    <= 24'd0;
    end else begin
      state     <= state_nxt;
      prio_b    <= prio_b_nxt;
      err_range <= err_nxt;
      wr_en     <= wr_en_nxt;
      wr_led    <= wr_led_nxt;
      wr_rgb    <= wr_rgb_nxt;
    end
  end

  always_ff @(posedge clk) begin
    idx      <= idx_nxt;
    fill_rgb <= fill_rgb_nxt;
  end

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Scoreboard bench for ws2812_write_arbiter: expected writes queued at accept, popped on each wr_en strobe.
module tb_ws2812_write_arbiter;

  localparam int NUM_LEDS = 8;

  typedef struct {
    logic [7:0]  led;
    logic [23:0] rgb;
  } wr_t;

  logic        clk, reset;
  logic        a_valid, a_ready, a_fill;
  logic [7:0]  a_led;
  logic [23:0] a_rgb;
  logic        b_valid, b_ready, b_fill;
  logic [7:0]  b_led;
  logic [23:0] b_rgb;
  logic        wr_en, busy, err_range;
  logic [7:0]  wr_led;
  logic [23:0] wr_rgb;
`ifdef WS2812_DIM_EN
  logic [2:0]  dim;
`endif

  int  n_checks = 0;
  int  n_errors = 0;
  bit  exp_prio_b = 0;
  wr_t sb[$];

  ws2812_write_arbiter #(.NUM_LEDS(NUM_LEDS)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_fill(a_fill), .a_led(a_led), .a_rgb(a_rgb),
    .b_valid(b_valid), .b_ready(b_ready), .b_fill(b_fill), .b_led(b_led), .b_rgb(b_rgb),
    .wr_en(wr_en), .wr_led(wr_led), .wr_rgb(wr_rgb), .busy(busy), .err_range(err_range)
`ifdef WS2812_DIM_EN
    , .dim(dim)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dim_model(input logic [23:0] c);
`ifdef WS2812_DIM_EN
    logic [23:0] r;
    for (int k = 0; k < 3; k++) r[k*8 +: 8] = c[k*8 +: 8] >> dim;
    return r;
`else
    return c;
`endif
  endfunction

  task automatic push(input logic [7:0] led, input logic [23:0] rgb);
    wr_t e;
    e.led = led;
    e.rgb = dim_model(rgb);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexp_wr", 32'(wr_en), 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_led", 32'(wr_led), 32'(e.led));
        check("wr_rgb", 32'(wr_rgb), 32'(e.rgb));
      end
    end
  end

  task automatic send(input bit is_b, input bit fill, input logic [7:0] led, input logic [23:0] rgb);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    if (is_b) begin
      b_valid = 1'b1; b_fill = fill; b_led = led; b_rgb = rgb;
    end else begin
      a_valid = 1'b1; a_fill = fill; a_led = led; a_rgb = rgb;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = is_b ? b_ready : a_ready;
    end
    if (got) begin
      if (fill) for (int i = 0; i < NUM_LEDS; i++) push(8'(i), rgb);
      else if (int'(led) < NUM_LEDS) push(led, rgb);
      exp_prio_b = !is_b;
    end else begin
      check(is_b ? "tmo_b" : "tmo_a", 32'(got), 32'd1);
    end
    @(posedge clk); #1;
    if (is_b) begin b_valid = 1'b0; b_fill = 1'b0; end
    else begin a_valid = 1'b0; a_fill = 1'b0; end
  endtask

  initial begin
    bit g;
    reset = 1'b1;
    a_valid = 1'b1; a_fill = 1'b0; a_led = 8'd0; a_rgb = 24'd0;
    b_valid = 1'b1; b_fill = 1'b0; b_led = 8'd0; b_rgb = 24'd0;
`ifdef WS2812_DIM_EN
    dim = 3'd0;
`endif
    // Reset: readies suppressed even with both requesters valid
    repeat (2) @(negedge clk);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_led", 32'(wr_led), 32'd0);
    check("rst_wr_rgb", 32'(wr_rgb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_range), 32'd0);

    // Single write, one-cycle latency, then silence
    send(1'b0, 1'b0, 8'd3, 24'h00FF00);
    @(negedge clk);
    check("single_lat", 32'(wr_en), 32'd1);
    repeat (3) @(negedge clk);
    check("single_quiet", 32'(wr_en), 32'd0);

    // B write hands priority back to A
    send(1'b1, 1'b0, 8'd5, 24'hC0FFEE);

    // Both valid: alternate grants
    @(posedge clk); #1;
    a_valid = 1'b1; a_led = 8'd1; a_rgb = 24'h010101;
    b_valid = 1'b1; b_led = 8'd2; b_rgb = 24'h020202;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      g = exp_prio_b;
      check("rr_a_ready", 32'(a_ready), 32'(!g));
      check("rr_b_ready", 32'(b_ready), 32'(g));
      if (i > 0) check("rr_strobe", 32'(wr_en), 32'd1);
      if (g) push(8'd2, 24'h020202); else push(8'd1, 24'h010101);
      exp_prio_b = !g;
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    check("rr_strobe_last", 32'(wr_en), 32'd1);

    // B fill while A waits with a single write
    send(1'b1, 1'b1, 8'd0, 24'h123456);
    a_valid = 1'b1; a_fill = 1'b0; a_led = 8'd4; a_rgb = 24'hAABBCC;
    for (int i = 0; i < NUM_LEDS; i++) begin
      @(negedge clk);
      check("fill_busy", 32'(busy), 32'd1);
      check("fill_wr_en", 32'(wr_en), 32'd1);
      check("fill_a_ready", 32'(a_ready), 32'd0);
    end
    @(negedge clk);
    check("fill_done_busy", 32'(busy), 32'd0);
    check("fill_after_a_ready", 32'(a_ready), 32'd1);
    push(8'd4, 24'hAABBCC);
    exp_prio_b = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(negedge clk);
    check("fill_after_a_wr", 32'(wr_en), 32'd1);

    // Out-of-range single write is dropped and flagged stickily
    send(1'b0, 1'b0, 8'd8, 24'hFFFFFF);
    @(negedge clk);
    check("oor_wr_en", 32'(wr_en), 32'd0);
    check("oor_err", 32'(err_range), 32'd1);
    send(1'b1, 1'b0, 8'd7, 24'h070707);
    repeat (4) @(negedge clk);
    check("oor_err_hold", 32'(err_range), 32'd1);

    // Reset during the third fill cycle aborts the fill
    send(1'b0, 1'b1, 8'd0, 24'h0F0F0F);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_prio_b = 1'b0;
    a_valid = 1'b1; a_fill = 1'b0; a_led = 8'd6; a_rgb = 24'h0000AA;
    b_valid = 1'b1; b_fill = 1'b0; b_led = 8'd0; b_rgb = 24'hBB0000;
    @(negedge clk);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err_range), 32'd0);
    check("abort_left", 32'(sb.size()), 32'(NUM_LEDS - 3));
    sb.delete();
    check("abort_a_first", 32'(a_ready), 32'd1);
    check("abort_b_wait", 32'(b_ready), 32'd0);
    push(8'd6, 24'h0000AA);
    @(negedge clk);
    check("abort_b_next", 32'(b_ready), 32'd1);
    push(8'd0, 24'hBB0000);
    exp_prio_b = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;

    // Colour path (shifted by dim when the option is built in)
`ifdef WS2812_DIM_EN
    dim = 3'd2;
`endif
    send(1'b1, 1'b0, 8'd2, 24'hFF8040);
    @(negedge clk);
    check("dim_wr_en", 32'(wr_en), 32'd1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
